imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequences the instruction-memory write port at power-up: receives a byte stream, assembles 32-bit little-endian words and writes them into consecutive instruction-memory word locations.
- Holds the core in reset until the image is fully loaded, then releases it.
- Sits between a byte source (UART receiver or testbench) and the imem write inputs (write, addr_in, data).

Parameters:
- DEPTH, 128, number of 32-bit words in instruction memory; larger images are rejected.
- TIMEOUT, 1024, maximum idle cycles allowed between accepted bytes while loading; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data is valid this cycle
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready
- imem_write  output  1  one-cycle write strobe to imem write
- imem_addr  output  32  word index to imem addr_in (not a byte address)
- imem_data  output  32  word to imem data
- cpu_rst  output  1  holds the core in reset while high
- done  output  1  image loaded, core released
- err  output  1  load aborted (oversize or timeout)

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE
  - rx_ready = 0, imem_write = 0, imem_addr = 0, imem_data = 0
  - cpu_rst = 1, done = 0, err = 0
  - byte counter, word counter, word count and timeout counter all = 0
- States: IDLE, HDR, LOAD, DONE, ERR. Every output is registered.
- IDLE: rx_ready = 0. On start, go to HDR and clear all counters, err and done; cpu_rst = 1.
- HDR:
  - rx_ready = 1.
  - Collect 4 bytes, little-endian (first byte goes to bits [7:0]), to form the 32-bit word count N.
  - On the 4th byte: N == 0 → DONE; N > DEPTH → ERR; otherwise → LOAD with word index = 0.
- LOAD:
  - rx_ready = 1.
  - Each accepted byte is shifted into bits [8*k+7:8*k] of the assembly register, k = byte index 0..3.
  - On acceptance of byte 3, the next cycle drives imem_write = 1 for exactly one cycle, with imem_addr = word index and imem_data = the assembled word. The word index then increments.
  - rx_ready stays high during the write cycle; the next word's byte 0 may be accepted in the same cycle.
  - After the write of word N-1, go to DONE, dropping rx_ready in the cycle following that write.
- DONE: rx_ready = 0, cpu_rst = 0, done = 1. Bytes are ignored. start launches a reload: cpu_rst is reasserted and done cleared in the cycle after start.
- ERR: rx_ready = 0, cpu_rst = 1, err = 1 (sticky). Only start or reset leaves ERR; start goes to HDR.
- Timeout:
  - In HDR and LOAD, the timeout counter increments every cycle without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT → ERR. A partial word is never written.
  - The counter is held at 0 in IDLE, DONE and ERR.
- Boundaries:
  - Throughput: back-to-back bytes at one per cycle are supported, i.e. one word every 4 cycles.
  - N == DEPTH is legal; the last write goes to index DEPTH-1. The word index never wraps.
  - start asserted while in HDR or LOAD is ignored.
  - Reset asserted mid-load aborts immediately: all outputs return to their reset values, and already-written imem words are left as they are.
  - An acceptance and a timeout expiry in the same cycle: the acceptance wins and the counter clears.

Test Plan:
- Basic load: reset, start, send header 02 00 00 00 then bytes 13 00 00 00 B7 27 00 00 → writes (addr 0, 0x00000013) and (addr 1, 0x000027B7), each a single-cycle strobe; then done = 1 and cpu_rst = 0.
- Empty image: start with header 00 00 00 00 → no imem_write; DONE reached the cycle after the 4th header byte; cpu_rst = 0.
- Oversize: header 81 00 00 00 with DEPTH = 128 → err = 1, cpu_rst = 1, no writes, rx_ready = 0; a following start re-enters HDR with err = 0.
- Gaps and timeout:
  - With TIMEOUT = 16, bytes separated by 15 idle cycles → load completes normally.
  - A 16-cycle gap after byte 2 of a word → ERR, and that word is never written.
- Reset and ignored start: assert reset after 6 of 12 data bytes → all outputs at reset values; a start pulse during LOAD has no effect on the state or the word index.
- Reload: from DONE, start → cpu_rst = 1 the next cycle; a 1-word image FF FF FF FF → write (addr 0, 0xFFFFFFFF), then done = 1.

Source files
------------

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Power-up loader for the instruction memory. Receives a byte
//               stream made of a 4-byte little-endian word count N followed by
//               N little-endian 32-bit words. Each word is written to the next
//               consecutive imem word index. The core is held in reset until
//               the whole image has been written.
// Ports       : clk, reset (async, active-high)
//               start              - pulse, begins a (re)load from IDLE/DONE/ERR
//               rx_data/rx_valid   - incoming byte stream
//               rx_ready           - loader can take a byte this cycle
//               imem_write/addr/data - imem write port (addr is a word index)
//               cpu_rst            - core reset, high until the image is loaded
//               done / err         - load finished / load aborted
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_write,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam int              C_TW      = $clog2(TIMEOUT + 1);
    localparam logic [31:0]     C_DEPTH   = 32'(DEPTH);
    localparam logic [C_TW-1:0] C_TIMEOUT = C_TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            r_state_q,      w_state_d;
    logic              r_rx_ready_q,   w_rx_ready_d;
    logic              r_imem_write_q, w_imem_write_d;
    logic [31:0]       r_imem_addr_q,  w_imem_addr_d;
    logic [31:0]       r_imem_data_q,  w_imem_data_d;
    logic              r_cpu_rst_q,    w_cpu_rst_d;
    logic              r_done_q,       w_done_d;
    logic              r_err_q,        w_err_d;
    logic [1:0]        r_byte_cnt_q,   w_byte_cnt_d;
    logic [31:0]       r_word_idx_q,   w_word_idx_d;
    logic [31:0]       r_word_cnt_q,   w_word_cnt_d;
    logic [C_TW-1:0]   r_tmo_cnt_q,    w_tmo_cnt_d;
    logic [23:0]       r_asm_q,        w_asm_d;   // bytes 0..2 of the word in flight

    logic              w_acc;
    logic [31:0]       w_word;
    logic [C_TW-1:0]   w_tmo_inc;
    logic              w_last_written;

    assign w_acc     = rx_valid && r_rx_ready_q;
    assign w_word    = {rx_data, r_asm_q};
    assign w_tmo_inc = r_tmo_cnt_q + C_TW'(1);
    // The index is bumped together with the write strobe, so during the write
    // cycle of word N-1 the index already equals N.
    assign w_last_written = r_imem_write_q && (r_word_idx_q == r_word_cnt_q);

    always_comb begin
        w_state_d      = r_state_q;
        w_rx_ready_d   = r_rx_ready_q;
        w_imem_write_d = 1'b0;
        w_imem_addr_d  = r_imem_addr_q;
        w_imem_data_d  = r_imem_data_q;
        w_cpu_rst_d    = r_cpu_rst_q;
        w_done_d       = r_done_q;
        w_err_d        = r_err_q;
        w_byte_cnt_d   = r_byte_cnt_q;
        w_word_idx_d   = r_word_idx_q;
        w_word_cnt_d   = r_word_cnt_q;
        w_tmo_cnt_d    = '0;
        w_asm_d        = r_asm_q;

        if (w_acc) begin
            w_byte_cnt_d = r_byte_cnt_q + 2'd1;
            case (r_byte_cnt_q)
                2'd0:    w_asm_d[7:0]   = rx_data;
                2'd1:    w_asm_d[15:8]  = rx_data;
                2'd2:    w_asm_d[23:16] = rx_data;
                default: w_asm_d        = r_asm_q;
            endcase
        end

        case (r_state_q)
            S_IDLE, S_DONE, S_ERR: begin
                w_byte_cnt_d = r_byte_cnt_q;
                w_asm_d      = r_asm_q;
                if (start) begin
                    w_state_d    = S_HDR;
                    w_rx_ready_d = 1'b1;
                    w_cpu_rst_d  = 1'b1;
                    w_done_d     = 1'b0;
                    w_err_d      = 1'b0;
                    w_byte_cnt_d = 2'd0;
                    w_word_idx_d = '0;
                    w_word_cnt_d = '0;
                    w_asm_d      = '0;
                end
            end

            S_HDR: begin
                if (w_acc) begin
                    if (r_byte_cnt_q == 2'd3) begin
                        w_word_cnt_d = w_word;
                        w_word_idx_d = '0;
                        if (w_word == 32'd0) begin
                            w_state_d    = S_DONE;
                            w_rx_ready_d = 1'b0;
                            w_cpu_rst_d  = 1'b0;
                            w_done_d     = 1'b1;
                        end else if (w_word > C_DEPTH) begin
                            w_state_d    = S_ERR;
                            w_rx_ready_d = 1'b0;
                            w_err_d      = 1'b1;
                        end else begin
                            w_state_d = S_LOAD;
                        end
                    end
                end else if (w_tmo_inc == C_TIMEOUT) begin
                    w_state_d    = S_ERR;
                    w_rx_ready_d = 1'b0;
                    w_err_d      = 1'b1;
                end else begin
                    w_tmo_cnt_d = w_tmo_inc;
                end
            end

            S_LOAD: begin
                if (w_last_written) begin
                    // Image complete; any byte offered in this cycle is surplus.
                    w_state_d    = S_DONE;
                    w_rx_ready_d = 1'b0;
                    w_cpu_rst_d  = 1'b0;
                    w_done_d     = 1'b1;
                    w_byte_cnt_d = r_byte_cnt_q;
                    w_asm_d      = r_asm_q;
                end else if (w_acc) begin
                    if (r_byte_cnt_q == 2'd3) begin
                        w_imem_write_d = 1'b1;
                        w_imem_addr_d  = r_word_idx_q;
                        w_imem_data_d  = w_word;
                        w_word_idx_d   = r_word_idx_q + 32'd1;
                    end
                end else if (w_tmo_inc == C_TIMEOUT) begin
                    w_state_d    = S_ERR;
                    w_rx_ready_d = 1'b0;
                    w_err_d      = 1'b1;
                end else begin
                    w_tmo_cnt_d = w_tmo_inc;
                end
            end

            default: begin
                w_state_d    = S_IDLE;
                w_rx_ready_d = 1'b0;
                w_cpu_rst_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_rx_ready_q   <= 1'b0;
            r_imem_write_q <= 1'b0;
            r_imem_addr_q  <= '0;
            r_imem_data_q  <= '0;
            r_cpu_rst_q    <= 1'b1;
            r_done_q       <= 1'b0;
            r_err_q        <= 1'b0;
            r_byte_cnt_q   <= '0;
            r_word_idx_q   <= '0;
            r_word_cnt_q   <= '0;
            r_tmo_cnt_q    <= '0;
            r_asm_q        <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_rx_ready_q   <= w_rx_ready_d;
            r_imem_write_q <= w_imem_write_d;
            r_imem_addr_q  <= w_imem_addr_d;
            r_imem_data_q  <= w_imem_data_d;
            r_cpu_rst_q    <= w_cpu_rst_d;
            r_done_q       <= w_done_d;
            r_err_q        <= w_err_d;
            r_byte_cnt_q   <= w_byte_cnt_d;
            r_word_idx_q   <= w_word_idx_d;
            r_word_cnt_q   <= w_word_cnt_d;
            r_tmo_cnt_q    <= w_tmo_cnt_d;
            r_asm_q        <= w_asm_d;
        end
    end

    assign rx_ready   = r_rx_ready_q;
    assign imem_write = r_imem_write_q;
    assign imem_addr  = r_imem_addr_q;
    assign imem_data  = r_imem_data_q;
    assign cpu_rst    = r_cpu_rst_q;
    assign done       = r_done_q;
    assign err        = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed testbench for imem_boot_loader (DEPTH=128,
//               TIMEOUT=16). Flags are compared as {rx_ready, imem_write,
//               cpu_rst, done, err}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int DEPTH   = 128;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_write;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_write (imem_write),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    int          checks   = 0;
    int          failures = 0;
    int          wr_cnt   = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    // Count write strobes mid-cycle; a one-cycle strobe is seen exactly once.
    always @(negedge clk) begin
        if (imem_write) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= imem_addr;
            last_data <= imem_data;
        end
    end

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic [4:0]  flags;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [4:0] flags_now();
        return {rx_ready, imem_write, cpu_rst, done, err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 ns after the edge.
    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        start    = s;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        repeat (gap) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, d);
    endtask

    task automatic send_hdr(input logic [7:0] n);
        send(n, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Basic 2-word load, cycle by cycle.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 5'b10100, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 5'b10100, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 8'h13, 5'b10100, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 5'b11100, 32'h0, 32'h00000013};
        vecs[9]  = '{1'b0, 1'b1, 8'hB7, 5'b10100, 32'h0, 32'h00000013};
        vecs[10] = '{1'b0, 1'b1, 8'h27, 5'b10100, 32'h0, 32'h00000013};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h00000013};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 5'b11100, 32'h1, 32'h000027B7};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 5'b00010, 32'h1, 32'h000027B7};
        vecs[14] = '{1'b0, 1'b1, 8'h5A, 5'b00010, 32'h1, 32'h000027B7};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 32'(flags_now()), 32'b00100);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_data", imem_data, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].s, vecs[i].v, vecs[i].d);
            chk($sformatf("basic_flags[%0d]", i), 32'(flags_now()), 32'(vecs[i].flags));
            chk($sformatf("basic_addr[%0d]", i), imem_addr, vecs[i].addr);
            chk($sformatf("basic_data[%0d]", i), imem_data, vecs[i].data);
        end
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd2);

        // Empty image: reload from DONE, header of zero words.
        cyc(1'b1, 1'b0, 8'h00);
        chk("empty_start_flags", 32'(flags_now()), 32'b10100);
        send_hdr(8'h00);
        chk("empty_done_flags", 32'(flags_now()), 32'b00010);
        chk("empty_wr_cnt", 32'(wr_cnt), 32'd2);

        // Oversize header (DEPTH+1 words).
        cyc(1'b1, 1'b0, 8'h00);
        send_hdr(8'h81);
        chk("oversize_flags", 32'(flags_now()), 32'b00101);
        cyc(1'b0, 1'b1, 8'h55);
        cyc(1'b0, 1'b0, 8'h00);
        chk("err_sticky_flags", 32'(flags_now()), 32'b00101);
        chk("oversize_wr_cnt", 32'(wr_cnt), 32'd2);
        cyc(1'b1, 1'b0, 8'h00);
        chk("err_restart_flags", 32'(flags_now()), 32'b10100);

        // Every byte preceded by 15 idle cycles; an ignored start in a gap.
        send(8'h02, 15); send(8'h00, 15); send(8'h00, 15); send(8'h00, 15);
        send(8'hAA, 15); send(8'hBB, 15); send(8'hCC, 15); send(8'hDD, 15);
        chk("gap_w0_flags", 32'(flags_now()), 32'b11100);
        chk("gap_w0_addr", imem_addr, 32'h0);
        chk("gap_w0_data", imem_data, 32'hDDCCBBAA);
        send(8'h01, 15);
        repeat (7) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("start_in_load_flags", 32'(flags_now()), 32'b10100);
        send(8'h02, 7);
        send(8'h03, 15); send(8'h04, 15);
        chk("gap_w1_flags", 32'(flags_now()), 32'b11100);
        chk("gap_w1_addr", imem_addr, 32'h1);
        chk("gap_w1_data", imem_data, 32'h04030201);
        cyc(1'b0, 1'b0, 8'h00);
        chk("gap_done_flags", 32'(flags_now()), 32'b00010);
        chk("gap_wr_cnt", 32'(wr_cnt), 32'd4);

        // Timeout after byte 2 of word 1.
        cyc(1'b1, 1'b0, 8'h00);
        send_hdr(8'h02);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0);
        repeat (15) cyc(1'b0, 1'b0, 8'h00);
        chk("tmo_not_yet_flags", 32'(flags_now()), 32'b10100);
        cyc(1'b0, 1'b0, 8'h00);
        chk("tmo_err_flags", 32'(flags_now()), 32'b00101);
        cyc(1'b0, 1'b1, 8'h88);
        cyc(1'b0, 1'b0, 8'h00);
        chk("tmo_wr_cnt", 32'(wr_cnt), 32'd5);
        chk("tmo_last_data", last_data, 32'h44332211);

        // Reset mid-load after 6 of 12 data bytes.
        cyc(1'b1, 1'b0, 8'h00);
        send_hdr(8'h03);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("start_in_load2_flags", 32'(flags_now()), 32'b10100);
        send(8'h05, 0); send(8'h06, 0);
        reset = 1'b1;
        #1;
        chk("midload_reset_flags", 32'(flags_now()), 32'b00100);
        chk("midload_reset_addr", imem_addr, 32'h0);
        chk("midload_reset_data", imem_data, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midload_wr_cnt", 32'(wr_cnt), 32'd6);

        // Reach DONE, then reload a 1-word image.
        cyc(1'b1, 1'b0, 8'h00);
        send_hdr(8'h00);
        chk("pre_reload_flags", 32'(flags_now()), 32'b00010);
        cyc(1'b1, 1'b0, 8'h00);
        chk("reload_start_flags", 32'(flags_now()), 32'b10100);
        send_hdr(8'h01);
        send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0);
        chk("reload_w_flags", 32'(flags_now()), 32'b11100);
        chk("reload_w_addr", imem_addr, 32'h0);
        chk("reload_w_data", imem_data, 32'hFFFFFFFF);
        cyc(1'b0, 1'b0, 8'h00);
        chk("reload_done_flags", 32'(flags_now()), 32'b00010);
        chk("reload_wr_cnt", 32'(wr_cnt), 32'd7);

        // Full-depth image, back-to-back bytes; word i holds value i.
        cyc(1'b1, 1'b0, 8'h00);
        send_hdr(8'h80);
        for (int w = 0; w < DEPTH; w++) begin
            send(8'(w), 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
            chk($sformatf("full_addr[%0d]", w), imem_addr, 32'(w));
            chk($sformatf("full_data[%0d]", w), imem_data, 32'(w));
        end
        chk("full_last_flags", 32'(flags_now()), 32'b11100);
        cyc(1'b0, 1'b0, 8'h00);
        chk("full_done_flags", 32'(flags_now()), 32'b00010);
        chk("full_wr_cnt", 32'(wr_cnt), 32'(7 + DEPTH));
        chk("full_last_addr", last_addr, 32'(DEPTH - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
